// File: rtl/jtag_uart_host_master.sv
// Avalon-MM initiator that streams bytes to and from a JTAG UART slave.
// Writes are gated by the WSPACE credit, and the data register is polled for receive bytes.
module jtag_uart_host_master #(
  parameter int unsigned POLL_INTERVAL = 256,
  parameter int unsigned WSPACE_MAX    = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic        avm_read_n,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        overflow_seen
);

  typedef enum logic [2:0] {StIdle, StRdCtrl, StWrData, StRdData, StGap} state_e;

  localparam logic [15:0] PollLoad  = 16'(POLL_INTERVAL);
  localparam logic [7:0]  WspaceMax = 8'(WSPACE_MAX);

  state_e      r_state, w_state_d;
  logic [7:0]  r_wspace;
  logic [6:0]  r_ravail;
  logic [15:0] r_poll;
  logic        r_rr_last;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;
  logic        r_overflow;
  logic        r_cs, r_addr, r_read_n, r_write_n;
  logic [7:0]  r_wdata;

  logic        w_done, w_tx_cand, w_rx_cand, w_ctrl_need, w_rr_toggle, w_access_d;
  logic [7:0]  w_ws_rd, w_ws_clamp;
  logic        w_unused;

  assign w_done      = r_cs & ~avm_waitrequest;
  assign w_ctrl_need = tx_valid & (r_wspace == 8'd0) & (r_poll == 16'd0);
  assign w_tx_cand   = tx_valid & (r_wspace != 8'd0);
  // A control refresh for a blocked sender outranks a purely speculative data poll.
  assign w_rx_cand   = ~r_rx_valid & ((r_ravail != 7'd0) | ((r_poll == 16'd0) & ~w_ctrl_need));
  assign w_ws_rd     = {1'b0, avm_readdata[22:16]};
  assign w_ws_clamp  = (w_ws_rd > WspaceMax) ? WspaceMax : w_ws_rd;
  assign w_unused    = ^{avm_readdata[31:23], avm_readdata[13:8]};

  always_comb begin
    w_state_d   = r_state;
    w_rr_toggle = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_tx_cand && w_rx_cand) begin
          w_state_d   = r_rr_last ? StRdData : StWrData;
          w_rr_toggle = 1'b1;
        end else if (w_tx_cand) begin
          w_state_d = StWrData;
        end else if (w_rx_cand) begin
          w_state_d = StRdData;
        end else if (w_ctrl_need) begin
          w_state_d = StRdCtrl;
        end
      end
      StRdCtrl, StWrData, StRdData: begin
        if (w_done) w_state_d = StGap;
      end
      StGap:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_access_d = (w_state_d == StRdCtrl) | (w_state_d == StWrData) |
                      (w_state_d == StRdData);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wspace   <= 8'd0;
      r_ravail   <= 7'd0;
      r_poll     <= 16'd0;
      r_rr_last  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'd0;
      r_overflow <= 1'b0;
      r_cs       <= 1'b0;
      r_addr     <= 1'b0;
      r_read_n   <= 1'b1;
      r_write_n  <= 1'b1;
      r_wdata    <= 8'd0;
    end else begin
      r_state   <= w_state_d;
      // Bus outputs are registered from the next state so they change together.
      r_cs      <= w_access_d;
      r_addr    <= (w_state_d == StRdCtrl);
      r_read_n  <= ~((w_state_d == StRdCtrl) | (w_state_d == StRdData));
      r_write_n <= ~(w_state_d == StWrData);
      if (r_state == StIdle && w_state_d == StWrData) r_wdata <= tx_data;
      if (w_rr_toggle) r_rr_last <= ~r_rr_last;
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

      if (w_done && r_state == StWrData) r_wspace <= r_wspace - 8'd1;
      if (w_done && r_state == StRdCtrl) r_wspace <= w_ws_clamp;

      if (w_done && (r_state == StRdCtrl || r_state == StRdData)) begin
        r_poll <= PollLoad;
      end else if (r_poll != 16'd0) begin
        r_poll <= r_poll - 16'd1;
      end

      if (w_done && r_state == StRdData) begin
        if (avm_readdata[15]) begin
          r_rx_data  <= avm_readdata[7:0];
          r_rx_valid <= 1'b1;
          r_ravail   <= avm_readdata[22:16];
        end else begin
          r_ravail <= 7'd0;
        end
        if (avm_readdata[14]) r_overflow <= 1'b1;
      end
    end
  end

  assign avm_chipselect = r_cs;
  assign avm_address    = r_addr;
  assign avm_read_n     = r_read_n;
  assign avm_write_n    = r_write_n;
  assign avm_writedata  = {24'd0, r_wdata};
  assign tx_ready       = (r_state == StWrData) & w_done & ~rst;
  assign rx_data        = r_rx_data;
  assign rx_valid       = r_rx_valid;
  assign overflow_seen  = r_overflow;

endmodule

// File: tb/tb_jtag_uart_host_master.sv
// Bench for jtag_uart_host_master: a table of expected bus transactions served by a
// slave model, plus hand sequences for reset, rx hold and mid-transaction reset.
module tb_jtag_uart_host_master;

  localparam int Poll = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        avm_address, avm_chipselect, avm_read_n, avm_write_n;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, overflow_seen;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done = 0;
  int last_rd_done = 0;

  typedef struct {
    logic        addr;
    logic        wr;
    logic [7:0]  wdata;
    int          stalls;
    logic [31:0] rdata;
    logic        from_rd;
    int          win;
    int          hold;
    logic        rdy_after;
    logic [7:0]  next_tx;
    logic        next_valid;
  } txn_t;

  jtag_uart_host_master #(.POLL_INTERVAL(Poll), .WSPACE_MAX(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_read_n      (avm_read_n),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .overflow_seen   (overflow_seen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic addr, input logic wr, input logic [7:0] wdata,
                              input int stalls, input logic [31:0] rdata,
                              input logic from_rd, input int win, input int hold,
                              input logic rdy_after, input logic [7:0] next_tx,
                              input logic next_valid);
    txn_t t;
    t.addr = addr; t.wr = wr; t.wdata = wdata; t.stalls = stalls; t.rdata = rdata;
    t.from_rd = from_rd; t.win = win; t.hold = hold; t.rdy_after = rdy_after;
    t.next_tx = next_tx; t.next_valid = next_valid;
    return t;
  endfunction

  // Waits for one access, checks it against t, answers it, then checks the gap cycle.
  task automatic serve(input string nm, input txn_t t);
    int n;
    int s;
    logic [34:0] snap;
    logic ok;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_chipselect && n < 200);
    chk({nm, " start"}, avm_chipselect, 1'b1);
    if (!avm_chipselect) return;
    s = cyc;
    chk({nm, " spacing"}, s - (t.from_rd ? last_rd_done : last_done), t.win);
    chk({nm, " address"}, avm_address, t.addr);
    chk({nm, " read_n"}, avm_read_n, t.wr);
    chk({nm, " write_n"}, avm_write_n, !t.wr);
    if (t.wr) chk({nm, " writedata"}, avm_writedata, {24'd0, t.wdata});
    snap = {avm_address, avm_read_n, avm_write_n, avm_writedata};
    ok = !tx_ready;
    for (int i = 0; i < t.stalls; i++) begin
      @(negedge clk);
      if ({avm_address, avm_read_n, avm_write_n, avm_writedata} !== snap ||
          avm_chipselect !== 1'b1 || tx_ready !== 1'b0) ok = 1'b0;
    end
    chk({nm, " stall-stable"}, ok, 1'b1);
    avm_waitrequest = 1'b0;
    avm_readdata    = t.rdata;
    #1;
    chk({nm, " tx_ready"}, tx_ready, t.wr);
    last_done = cyc;
    if (!t.wr) last_rd_done = cyc;
    @(negedge clk);
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'd0;
    chk({nm, " gap"}, avm_chipselect, 1'b0);
    if (!t.wr && !t.addr) begin
      chk({nm, " rx_valid"}, rx_valid, t.rdata[15]);
      if (t.rdata[15]) chk({nm, " rx_data"}, rx_data, t.rdata[7:0]);
    end
  endtask

  initial begin
    txn_t tbl[18];
    txn_t t;
    logic hold_ok;
    int n;
    // Poll-driven accesses start Poll+2 cycles after the reloading read completes.
    tbl[0]  = mk(1, 0, 8'h00, 1, 32'h0003_0000, 0, 1,        0,  0, 8'h41, 1);
    tbl[1]  = mk(0, 1, 8'h41, 1, 32'h0,         0, 3,        0,  0, 8'h42, 1);
    tbl[2]  = mk(0, 1, 8'h42, 1, 32'h0,         0, 3,        0,  0, 8'h43, 1);
    tbl[3]  = mk(0, 1, 8'h43, 5, 32'h0,         0, 3,        0,  0, 8'h44, 1);
    tbl[4]  = mk(1, 0, 8'h00, 1, 32'h0005_0000, 1, Poll + 2, 0,  0, 8'h44, 1);
    tbl[5]  = mk(0, 1, 8'h44, 2, 32'h0,         0, 3,        0,  0, 8'h00, 0);
    tbl[6]  = mk(0, 0, 8'h00, 1, 32'h0002_8055, 1, Poll + 2, 10, 0, 8'h00, 0);
    tbl[7]  = mk(0, 0, 8'h00, 1, 32'h0001_8056, 0, 13,       0,  1, 8'h00, 0);
    tbl[8]  = mk(0, 0, 8'h00, 1, 32'h0000_8057, 0, 3,        0,  1, 8'h00, 0);
    tbl[9]  = mk(0, 0, 8'h00, 3, 32'h0000_4000, 1, Poll + 2, 0,  1, 8'h00, 0);
    tbl[10] = mk(0, 0, 8'h00, 1, 32'h0000_0000, 1, Poll + 2, 0,  1, 8'h00, 0);
    tbl[11] = mk(0, 0, 8'h00, 1, 32'h0005_8070, 1, Poll + 2, 0,  1, 8'h61, 1);
    tbl[12] = mk(0, 1, 8'h61, 1, 32'h0,         0, 3,        0,  1, 8'h62, 1);
    tbl[13] = mk(0, 0, 8'h00, 1, 32'h0004_8071, 0, 3,        0,  1, 8'h62, 1);
    tbl[14] = mk(0, 1, 8'h62, 1, 32'h0,         0, 3,        0,  1, 8'h63, 1);
    tbl[15] = mk(0, 0, 8'h00, 1, 32'h0003_8072, 0, 3,        0,  1, 8'h63, 1);
    tbl[16] = mk(0, 1, 8'h63, 1, 32'h0,         0, 3,        0,  1, 8'h00, 0);
    tbl[17] = mk(0, 0, 8'h00, 1, 32'h0000_8073, 0, 3,        0,  1, 8'h00, 0);

    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h41; rx_ready = 1'b0;
    avm_waitrequest = 1'b1; avm_readdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset chipselect", avm_chipselect, 1'b0);
    chk("reset read_n", avm_read_n, 1'b1);
    chk("reset write_n", avm_write_n, 1'b1);
    chk("reset address", avm_address, 1'b0);
    chk("reset writedata", avm_writedata, 32'd0);
    chk("reset tx_ready", tx_ready, 1'b0);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset rx_data", rx_data, 8'd0);
    chk("reset overflow", overflow_seen, 1'b0);
    rst = 1'b0;
    last_done = cyc;
    last_rd_done = cyc;

    for (int i = 0; i < 18; i++) begin
      t = tbl[i];
      serve($sformatf("txn%0d", i), t);
      tx_data  = t.next_tx;
      tx_valid = t.next_valid;
      if (t.hold > 0) begin
        hold_ok = 1'b1;
        repeat (t.hold) begin
          @(negedge clk);
          if (avm_chipselect !== 1'b0 || rx_valid !== 1'b1 || rx_data !== t.rdata[7:0])
            hold_ok = 1'b0;
        end
        chk($sformatf("txn%0d rx hold", i), hold_ok, 1'b1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
      rx_ready = t.rdy_after;
    end

    chk("overflow sticky", overflow_seen, 1'b1);
    repeat (3) @(negedge clk);
    chk("overflow still set", overflow_seen, 1'b1);

    // Reset lands while a write is stalled; the slave completes in that very cycle.
    tx_data = 8'h7A; tx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_chipselect && n < 200);
    chk("mid start", avm_chipselect, 1'b1);
    chk("mid write_n", avm_write_n, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    avm_waitrequest = 1'b0;
    #1;
    chk("mid tx_ready suppressed", tx_ready, 1'b0);
    @(negedge clk);
    avm_waitrequest = 1'b1;
    chk("mid chipselect dropped", avm_chipselect, 1'b0);
    chk("mid overflow cleared", overflow_seen, 1'b0);
    chk("mid rx_valid", rx_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_done = cyc;
    last_rd_done = cyc;
    serve("post-reset ctrl", mk(1, 0, 8'h00, 1, 32'h007F_0000, 0, 1, 0, 0, 8'h7A, 1));
    serve("post-reset write", mk(0, 1, 8'h7A, 1, 32'h0, 0, 3, 0, 0, 8'h00, 0));
    tx_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
